// File: rtl/monitor_report_pkg.sv
// Shared constants and record type for the monitor report collector.
// A record pairs a symbol index with the report lines seen on that symbol.
package monitor_report_pkg;

  localparam int DEF_NUM_REPORTS = 36;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_CYCLE_W     = 32;
  localparam int DEF_DROP_W      = 16;

  typedef struct packed {
    logic [DEF_CYCLE_W-1:0]     cycle;
    logic [DEF_NUM_REPORTS-1:0] vector;
  } report_rec_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO of report records.
// Extra pointer MSB tells full from empty.
module report_fifo
  import monitor_report_pkg::*;
#(
  parameter type T     = report_rec_t,
  parameter int  DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/monitor_report_collector.sv
// Turns per-symbol report lines into {index, vector} records.
// Overflow drops records instead of stalling the symbol stream.
module monitor_report_collector
  import monitor_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CYCLE_W     = DEF_CYCLE_W,
  parameter int DROP_W      = DEF_DROP_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_in,
  input  logic                   clear,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [CYCLE_W-1:0]     rpt_cycle,
  output logic [NUM_REPORTS-1:0] rpt_vector,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  typedef struct packed {
    logic [CYCLE_W-1:0]     cycle;
    logic [NUM_REPORTS-1:0] vector;
  } rec_t;

  localparam logic [CYCLE_W-1:0] IDX_ONE  = 1;
  localparam logic [DROP_W-1:0]  DROP_ONE = 1;
  localparam logic [DROP_W-1:0]  DROP_MAX = '1;

  logic [CYCLE_W-1:0] sym_idx;
  rec_t               din;
  rec_t               dout;
  logic               full;
  logic               empty;
  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;

  assign capture = run && (report_in != '0);
  assign rpt_valid = !empty;
  assign pop  = rpt_valid && rpt_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  assign din.cycle  = sym_idx;
  assign din.vector = report_in;

  assign rpt_cycle  = rpt_valid ? dout.cycle  : '0;
  assign rpt_vector = rpt_valid ? dout.vector : '0;

  report_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_idx <= '0;
    end else if (run) begin
      sym_idx <= sym_idx + IDX_ONE;
    end
  end

  // A drop in the same cycle as clear leaves a count of one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear) begin
        drop_count <= DROP_ONE;
      end else if (drop_count != DROP_MAX) begin
        drop_count <= drop_count + DROP_ONE;
      end
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_monitor_report_collector.sv
// Directed bench for monitor_report_collector.
// Table of per-cycle vectors plus hand-written corner sequences.
module tb_monitor_report_collector;

  localparam int NR  = 36;
  localparam int CW  = 32;
  localparam int DW  = 16;
  localparam int CW4 = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [NR-1:0] report_in;
  logic          clear;
  logic          rpt_ready;
  logic          rpt_valid;
  logic [CW-1:0] rpt_cycle;
  logic [NR-1:0] rpt_vector;
  logic          overflow;
  logic [DW-1:0] drop_count;

  logic           run_w;
  logic [NR-1:0]  rep_w;
  logic           rdy_w;
  logic           valid_w;
  logic [CW4-1:0] cyc_w;
  logic [NR-1:0]  vec_w;
  logic           ovf_w;
  logic [DW-1:0]  drop_w;
  logic           clear_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monitor_report_collector dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .report_in  (report_in),
    .clear      (clear),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_cycle  (rpt_cycle),
    .rpt_vector (rpt_vector),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  monitor_report_collector #(.CYCLE_W(CW4)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .run        (run_w),
    .report_in  (rep_w),
    .clear      (clear_w),
    .rpt_valid  (valid_w),
    .rpt_ready  (rdy_w),
    .rpt_cycle  (cyc_w),
    .rpt_vector (vec_w),
    .overflow   (ovf_w),
    .drop_count (drop_w)
  );

  typedef struct {
    logic          run;
    logic [NR-1:0] rep;
    logic          rdy;
    logic          clr;
    logic          v;
    logic [CW-1:0] cyc;
    logic [NR-1:0] vec;
    logic          ovf;
    logic [DW-1:0] drop;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [63:0] c, input logic [63:0] vec,
                         input logic o, input logic [63:0] d);
    chk({tag, ".valid"},  64'(rpt_valid),  64'(v));
    chk({tag, ".cycle"},  64'(rpt_cycle),  c);
    chk({tag, ".vector"}, 64'(rpt_vector), vec);
    chk({tag, ".ovf"},    64'(overflow),   64'(o));
    chk({tag, ".drop"},   64'(drop_count), d);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; report_in = '0; clear = 1'b0;
    rpt_ready = 1'b0;
    run_w = 1'b0; rep_w = '0; rdy_w = 1'b0; clear_w = 1'b0;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b1, 36'h0, 1'b0, 1'b0,
                 1'b0, 32'd0, 36'h0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 36'h1, 1'b0, 1'b0,
                1'b1, 32'd5, 36'h1, 1'b0, 16'd0};
    for (int i = 6; i < 9; i++)
      tbl[i] = '{1'b0, 36'h8, 1'b0, 1'b0,
                 1'b1, 32'd5, 36'h1, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 36'h0, 1'b1, 1'b0,
                1'b0, 32'd0, 36'h0, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 36'h2, 1'b0, 1'b0,
                1'b1, 32'd7, 36'h2, 1'b0, 16'd0};

    #1;
    chk_out("reset", 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // basic capture, run=0 masking, pop to empty
    for (int i = 0; i < 11; i++) begin
      run = tbl[i].run; report_in = tbl[i].rep;
      rpt_ready = tbl[i].rdy; clear = tbl[i].clr;
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].v, 64'(tbl[i].cyc),
              64'(tbl[i].vec), tbl[i].ovf, 64'(tbl[i].drop));
    end

    // overflow: 10 captures into 8 entries
    run = 1'b0; report_in = '0; rpt_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run = 1'b1; report_in = NR'(i + 1);
      step();
    end
    chk_out("ovf_full", 1'b1, 64'd0, 64'd1, 1'b1, 64'd2);

    // full: capture with simultaneous pop is not a drop
    run = 1'b1; report_in = 36'hAA; rpt_ready = 1'b1;
    step();
    chk_out("full_pushpop", 1'b1, 64'd1, 64'd2, 1'b1, 64'd2);

    run = 1'b0; report_in = '0;
    for (int k = 1; k <= 8; k++) begin
      chk_out($sformatf("drain%0d", k), 1'b1,
              (k < 8) ? 64'(k) : 64'd10,
              (k < 8) ? 64'(k + 1) : 64'hAA, 1'b1, 64'd2);
      step();
    end
    chk_out("drained", 1'b0, 64'd0, 64'd0, 1'b1, 64'd2);

    // clear, then drop in the same cycle as clear
    rpt_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk_out("clear", 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    for (int i = 0; i < 8; i++) begin
      run = 1'b1; report_in = 36'h1;
      step();
    end
    run = 1'b1; report_in = 36'h3; clear = 1'b1;
    step();
    clear = 1'b0;
    chk_out("drop_clear", 1'b1, 64'd11, 64'd1, 1'b1, 64'd1);
    step();
    run = 1'b0; report_in = '0;
    chk_out("drop_again", 1'b1, 64'd11, 64'd1, 1'b1, 64'd2);

    // asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1; report_in = 36'h5;
    step();
    run = 1'b0; report_in = '0;
    chk_out("post_rst", 1'b1, 64'd0, 64'd5, 1'b0, 64'd0);

    // 4-bit index wraps: 17th symbol has index 0
    for (int i = 0; i < 16; i++) begin
      run_w = 1'b1; rep_w = '0;
      step();
    end
    chk("wrap.idle_valid", 64'(valid_w), 64'd0);
    rep_w = 36'h9;
    step();
    run_w = 1'b0; rep_w = '0;
    chk("wrap.valid",  64'(valid_w), 64'd1);
    chk("wrap.cycle",  64'(cyc_w),   64'd0);
    chk("wrap.vector", 64'(vec_w),   64'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/monitor_report_collector.md
# monitor_report_collector

Consumes the per-cycle report lines driven by a monitor automata stage and turns them into timestamped report records for the downstream consumer. Each run cycle with at least one asserted report line becomes one record of {symbol index, report vector}, buffered in a small FIFO and drained over a valid/ready interface. Overflow is flagged and counted rather than stalling the symbol stream. The block sits beside the cluster stage and shares its clk, reset and run.

## Interface
- NUM_REPORTS, 36: width of the report vector (all report outputs of one cluster, concatenated).
- DEPTH, 8: FIFO entries; a power of two, at least 2.
- CYCLE_W, 32: width of the symbol index counter.
- DROP_W, 16: width of the dropped-record counter.

- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  the stage consumes a symbol this cycle; same signal the stage receives.
- report_in  in  NUM_REPORTS  report lines from the stage, sampled with run.
- clear  in  1  synchronous clear of overflow and drop_count.
- rpt_valid  out  1  head record available.
- rpt_ready  in  1  consumer accepts the head record.
- rpt_cycle  out  CYCLE_W  symbol index of the head record.
- rpt_vector  out  NUM_REPORTS  report vector of the head record.
- overflow  out  1  sticky; set when a record was dropped.
- drop_count  out  DROP_W  dropped records, saturating.

## Operation
- Symbol index counter sym_idx: increments by 1 on every cycle with run=1 and wraps modulo 2^CYCLE_W. The first symbol after reset has index 0.
- Capture condition: run=1 and report_in != 0. The record is {sym_idx before increment, report_in}.
- Cycles with run=0 never capture, even when report_in is nonzero.
- Pop: rpt_valid && rpt_ready.
- Push accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle. Simultaneous push and pop keeps the occupancy unchanged.
- Drop: capture && full && !pop. On a drop, the record is discarded, overflow is set to 1 and drop_count increments, saturating at 2^DROP_W-1.
- clear=1 sets overflow to 0 and drop_count to 0. If a drop occurs in the same cycle as clear, the drop wins: overflow=1 and drop_count=1.
- rpt_valid equals FIFO not-empty. While rpt_valid=0, rpt_cycle and rpt_vector are driven as 0.
- Records leave in capture order. The head record is held stable while rpt_valid && !rpt_ready.
- rpt_ready is ignored while rpt_valid=0.
- Reset, including mid-operation, behaves as follows:
  - All buffered records are discarded.
  - sym_idx, overflow and drop_count go to 0.
  - rpt_valid, rpt_cycle and rpt_vector go to 0.

## Timing
- Reset values: rpt_valid=0, rpt_cycle=0, rpt_vector=0, overflow=0, drop_count=0. These are applied asynchronously when reset asserts.
- Capture latency: a capture sampled at edge N makes the record visible with rpt_valid=1 after edge N, with an empty FIFO and no combinational path from report_in.
- Pop at edge N: the next record, or rpt_valid=0, is presented after edge N.
- With rpt_ready held at 1 and one capture per cycle, the FIFO sustains one record per cycle with no drops.
- overflow and drop_count update at the edge where the drop is sampled.
- The rpt_* outputs come from registers or memory read at rd_ptr. There is no combinational path from rpt_ready to rpt_valid.

## Structure
- Package monitor_report_pkg holds:
  - the default constants (NUM_REPORTS, DEPTH, CYCLE_W, DROP_W);
  - the record struct report_rec_t {cycle, vector}.
- Sub-module report_fifo: a synchronous FIFO of report_rec_t.
  - Pointers are log2(DEPTH)+1 bits, with full/empty taken from the MSB compare.
  - Ports: push, pop, din, dout, full, empty.
- The top level contains the index counter, capture logic, drop/overflow logic and output gating.

## Test plan
- Reset, then 5 run cycles with report_in=0, then run with report_in=36'h1 -> one record with rpt_cycle=5, rpt_vector=36'h1; rpt_valid rises one cycle after capture.
- report_in=36'h8 with run=0 for 3 cycles -> no record; sym_idx unchanged.
- rpt_ready=0, 10 consecutive capturing run cycles, DEPTH=8 -> 8 records held (indices 0..7); overflow=1, drop_count=2; draining yields indices 0..7 in order.
- FIFO full, capture and pop in the same cycle -> no drop, occupancy stays 8, and the new record is last.
- CYCLE_W=4, 17 run cycles with capture on the 17th -> rpt_cycle=0 (wrap).
- 3 records buffered and overflow=1, assert reset mid-stream -> rpt_valid, overflow, drop_count and rpt_* are 0 immediately; the next capture has rpt_cycle=0.
